// File: rtl/fetch_pkg.sv
// ============================================================================
//  Module   : fetch_pkg
//  Purpose  : Shared types and constants for the instruction-fetch sequencer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        KILL  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned PC_STEP  = 4;

    // IF_ID field bounds: {pc_of_instr, instr}
    localparam int PC_HI = 63;
    localparam int PC_LO = 32;
    localparam int IN_HI = 31;
    localparam int IN_LO = 0;

endpackage

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ============================================================================
//  Module   : fetch_sequencer
//  Purpose  : Owns the PC, runs a req/ack instruction-memory port and loads
//             the IF_ID register, honouring decode stall and branch redirect.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(fetch_pkg::RESET_PC),
    parameter int unsigned       PC_STEP  = fetch_pkg::PC_STEP
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        stall,
    input  logic                        redirect,
    input  logic [ADDR_W-1:0]           redirect_pc,
    output logic                        imem_req,
    output logic [ADDR_W-1:0]           imem_addr,
    input  logic                        imem_ack,
    input  logic [INSTR_W-1:0]          imem_rdata,
    output logic [ADDR_W-1:0]           PC,
    output logic [ADDR_W+INSTR_W-1:0]   IF_ID,
    output logic                        if_id_valid
);

    localparam logic [ADDR_W-1:0] C_STEP = ADDR_W'(PC_STEP);

    fetch_state_t                r_state, w_state_n;
    logic [ADDR_W-1:0]           r_pc, w_pc_n;
    logic [ADDR_W-1:0]           r_kill_addr, w_kill_addr_n;
    logic [INSTR_W-1:0]          r_buf, w_buf_n;
    logic [ADDR_W+INSTR_W-1:0]   r_if_id, w_if_id_n;
    logic                        r_valid, w_valid_n;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_pc        <= RESET_PC;
            r_kill_addr <= '0;
            r_buf       <= '0;
            r_if_id     <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_pc        <= w_pc_n;
            r_kill_addr <= w_kill_addr_n;
            r_buf       <= w_buf_n;
            r_if_id     <= w_if_id_n;
            r_valid     <= w_valid_n;
        end
    end

    always_comb begin
        w_state_n     = r_state;
        w_pc_n        = r_pc;
        w_kill_addr_n = r_kill_addr;
        w_buf_n       = r_buf;
        w_if_id_n     = r_if_id;
        w_valid_n     = r_valid;

        case (r_state)
            IDLE: begin
                if (redirect) w_pc_n = redirect_pc;
                w_state_n = FETCH;
            end
            FETCH: begin
                if (redirect) begin
                    w_pc_n    = redirect_pc;
                    w_if_id_n = '0;
                    w_valid_n = 1'b0;
                    // Without an ack the old request is still in flight and
                    // must be drained at its original address.
                    if (!imem_ack) begin
                        w_kill_addr_n = r_pc;
                        w_state_n     = KILL;
                    end
                end else if (imem_ack && !stall) begin
                    w_if_id_n = {r_pc, imem_rdata};
                    w_valid_n = 1'b1;
                    w_pc_n    = r_pc + C_STEP;
                end else if (imem_ack && stall) begin
                    w_buf_n   = imem_rdata;
                    w_state_n = HOLD;
                end else if (!stall) begin
                    w_valid_n = 1'b0;
                end
            end
            HOLD: begin
                if (redirect) begin
                    w_pc_n    = redirect_pc;
                    w_if_id_n = '0;
                    w_valid_n = 1'b0;
                    w_buf_n   = '0;
                    w_state_n = FETCH;
                end else if (!stall) begin
                    w_if_id_n = {r_pc, r_buf};
                    w_valid_n = 1'b1;
                    w_pc_n    = r_pc + C_STEP;
                    w_state_n = FETCH;
                end
            end
            KILL: begin
                if (redirect) w_pc_n = redirect_pc;
                if (imem_ack) w_state_n = FETCH;
            end
            default: w_state_n = IDLE;
        endcase
    end

    assign imem_req    = (r_state == FETCH) || (r_state == KILL);
    assign imem_addr   = (r_state == KILL) ? r_kill_addr : r_pc;
    assign PC          = r_pc;
    assign IF_ID       = r_if_id;
    assign if_id_valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ============================================================================
//  Module   : tb_fetch_sequencer
//  Purpose  : Directed self-checking bench for fetch_sequencer with a
//             configurable-latency instruction memory model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] PC;
    logic [63:0] IF_ID;
    logic        if_id_valid;

    int n_cmp = 0;
    int n_err = 0;

    // Memory model: acks once the request has waited ack_wait cycles.
    int   wait_cnt = 0;
    int   ack_wait = 0;
    logic ack_en   = 1'b1;

    assign imem_ack   = ack_en && imem_req && (wait_cnt >= ack_wait);
    assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

    always @(posedge clock) begin
        if (reset || !imem_req || imem_ack) wait_cnt <= 0;
        else                                wait_cnt <= wait_cnt + 1;
    end

    always #5 clock = ~clock;

    fetch_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .PC          (PC),
        .IF_ID       (IF_ID),
        .if_id_valid (if_id_valid)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (5) tick();
        reset = 1'b0;
    endtask

    initial begin
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;

        // 1: reset state, then zero-wait streaming
        do_reset();
        reset = 1'b1; tick();
        check("rst_pc",    {32'h0, PC}, 64'h0);
        check("rst_ifid",  IF_ID, 64'h0);
        check("rst_valid", {63'h0, if_id_valid}, 64'h0);
        check("rst_req",   {63'h0, imem_req}, 64'h0);
        reset = 1'b0;
        tick();
        check("t1_req",  {63'h0, imem_req}, 64'h1);
        check("t1_addr", {32'h0, imem_addr}, 64'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t1_ifid",  IF_ID, {32'(i * 4), 32'(i * 4) ^ 32'hA5A5_0000});
            check("t1_valid", {63'h0, if_id_valid}, 64'h1);
            check("t1_pc",    {32'h0, PC}, 64'(32'((i + 1) * 4)));
        end

        // 2: three-cycle ack latency
        ack_wait = 2;
        do_reset();
        tick();
        check("t2_addr_a", {32'h0, imem_addr}, 64'h0);
        tick();
        check("t2_valid_a", {63'h0, if_id_valid}, 64'h0);
        check("t2_addr_b",  {32'h0, imem_addr}, 64'h0);
        tick();
        check("t2_addr_c",  {32'h0, imem_addr}, 64'h0);
        check("t2_req_c",   {63'h0, imem_req}, 64'h1);
        tick();
        check("t2_ifid",  IF_ID, 64'h0000_0000_A5A5_0000);
        check("t2_valid", {63'h0, if_id_valid}, 64'h1);
        check("t2_pc",    {32'h0, PC}, 64'h4);
        tick();
        check("t2_bubble", {63'h0, if_id_valid}, 64'h0);
        check("t2_addr_d", {32'h0, imem_addr}, 64'h4);
        ack_wait = 0;

        // 3: stall while ack for PC=8 arrives
        do_reset();
        tick(); tick(); tick();
        stall = 1'b1;
        tick();
        check("t3_hold_req", {63'h0, imem_req}, 64'h0);
        check("t3_hold_pc",  {32'h0, PC}, 64'h8);
        repeat (3) tick();
        check("t3_frozen",   IF_ID, 64'h0000_0004_A5A5_0004);
        check("t3_frz_vld",  {63'h0, if_id_valid}, 64'h1);
        stall = 1'b0;
        tick();
        check("t3_ifid", IF_ID, 64'h0000_0008_A5A5_0008);
        check("t3_pc",   {32'h0, PC}, 64'hC);

        // 4: redirect to 0x100 while waiting on PC=0x10
        do_reset();
        repeat (5) tick();
        ack_en = 1'b0;
        check("t4_pc10", {32'h0, PC}, 64'h10);
        tick();
        redirect = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        check("t4_kill_addr",  {32'h0, imem_addr}, 64'h10);
        check("t4_kill_req",   {63'h0, imem_req}, 64'h1);
        check("t4_kill_pc",    {32'h0, PC}, 64'h100);
        check("t4_kill_ifid",  IF_ID, 64'h0);
        ack_en = 1'b1;
        tick();
        check("t4_drop_valid", {63'h0, if_id_valid}, 64'h0);
        check("t4_new_addr",   {32'h0, imem_addr}, 64'h100);
        tick();
        check("t4_ifid",  IF_ID, 64'h0000_0100_A5A5_0100);
        check("t4_valid", {63'h0, if_id_valid}, 64'h1);

        // 5: redirect and stall together in HOLD
        do_reset();
        tick(); tick(); tick();
        stall = 1'b1;
        tick();
        redirect = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect = 1'b0; stall = 1'b0;
        check("t5_valid", {63'h0, if_id_valid}, 64'h0);
        check("t5_ifid",  IF_ID, 64'h0);
        check("t5_addr",  {32'h0, imem_addr}, 64'h40);
        tick();
        check("t5_next", IF_ID, 64'h0000_0040_A5A5_0040);

        // 6: reset in the middle of a wait at PC=0x20
        do_reset();
        repeat (9) tick();
        check("t6_pc20", {32'h0, PC}, 64'h20);
        ack_en = 1'b0;
        tick();
        check("t6_bubble", {63'h0, if_id_valid}, 64'h0);
        check("t6_held",   IF_ID, 64'h0000_001C_A5A5_001C);
        reset = 1'b1;
        tick();
        reset = 1'b0; ack_en = 1'b1;
        check("t6_req",   {63'h0, imem_req}, 64'h0);
        check("t6_pc",    {32'h0, PC}, 64'h0);
        check("t6_ifid",  IF_ID, 64'h0);
        check("t6_valid", {63'h0, if_id_valid}, 64'h0);

        // 6b: PC wraps from 0xFFFFFFFC to 0
        do_reset();
        tick();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        check("t6b_pc",    {32'h0, PC}, 64'hFFFF_FFFC);
        check("t6b_valid", {63'h0, if_id_valid}, 64'h0);
        tick();
        check("t6b_ifid", IF_ID, 64'hFFFF_FFFC_5A5A_FFFC);
        check("t6b_wrap", {32'h0, PC}, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
